opl_timer_bank: RTL and testbench

- Parametrised bank of NUM_TIMERS 8-bit up-counting interval timers for the OPL/AdLib register window.
- Provides an index/data register interface, a status byte, an IRQ, per-timer masking and per-timer one-shot mode.
- Supports register read-back, including live counts.
- Sits beside the FM synthesis core on the same bus strobes; it replaces the fixed two-timer status logic and generalises the 80 µs / 320 µs timer pair.

---
 rtl/opl_timer_pkg.sv | 24 ++
 rtl/opl_timer_bank_if.sv | 24 ++
 rtl/opl_timer_unit.sv | 66 ++++++
 rtl/opl_timer_bank.sv | 130 +++++++++++++
 tb/tb_opl_timer_bank.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opl_timer_pkg.sv
// opl_timer_pkg: shared constants for the OPL timer bank.
// Default register indices, status bit positions, sub-counter width.
package opl_timer_pkg;

    localparam logic [8:0] IDX_PRESET_D = 9'h002;
    localparam logic [8:0] IDX_CTRL_D   = 9'h004;
    localparam logic [8:0] IDX_MASK_D   = 9'h104;
    localparam logic [8:0] IDX_MODE_D   = 9'h105;
    localparam logic [8:0] IDX_COUNT_D  = 9'h110;

    // Status byte: bit 7 = any flag, bit 6-i = flag[i]
    localparam int STAT_ANY   = 7;
    localparam int STAT_FLAG0 = 6;

    // Widest timer unit is (period_base+1) << ((nt-1)*us)
    function automatic int sub_width(
        input int pw,
        input int us,
        input int nt
    );
        return pw + us * (nt - 1);
    endfunction

endpackage

// File: rtl/opl_timer_bank_if.sv
// opl_timer_bank_if: index/data register bus of the timer bank.
// addr/din/we from the host, dout back from the bank.
interface opl_timer_bank_if;

    logic [1:0] addr;
    logic [7:0] din;
    logic       we;
    logic [7:0] dout;

    modport master (
        output addr,
        output din,
        output we,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  we,
        output dout
    );

endinterface

// File: rtl/opl_timer_unit.sv
// opl_timer_unit: one 8-bit up-counting interval timer.
// Ports: clk, rst_n, period_base, start, oneshot, preset -> cnt, pulse, stop_req.
module opl_timer_unit
    import opl_timer_pkg::*;
#(
    parameter int PERIOD_W   = 13,
    parameter int UNIT_SHIFT = 2,
    parameter int SUB_W      = 13,
    parameter int TIMER_IDX  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period_base,
    input  logic                start,
    input  logic                oneshot,
    input  logic [7:0]          preset,
    output logic [7:0]          cnt,
    output logic                pulse,
    output logic                stop_req
);

    logic             act_d;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] reload;
    logic [SUB_W:0]   base_len;
    logic [SUB_W:0]   unit_len;
    logic             wrap;

    // One extra bit so period_base+1 cannot overflow before the shift
    assign base_len = (SUB_W+1)'(period_base) + (SUB_W+1)'(1);
    assign unit_len = base_len << (TIMER_IDX * UNIT_SHIFT);
    assign reload   = SUB_W'(unit_len - (SUB_W+1)'(1));

    assign wrap     = start & act_d & (sub == '0) & (cnt == 8'hFF);
    // Top clears the start bit on the same edge that raises pulse
    assign stop_req = wrap & oneshot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d <= 1'b0;
            sub   <= '0;
            cnt   <= 8'h00;
            pulse <= 1'b0;
        end else begin
            act_d <= start;
            pulse <= 1'b0;
            if (start && !act_d) begin
                cnt <= preset;
                sub <= reload;
            end else if (start) begin
                if (sub == '0) begin
                    sub <= reload;
                    if (cnt == 8'hFF) begin
                        cnt   <= preset;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    sub <= sub - SUB_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/opl_timer_bank.sv
// opl_timer_bank: NUM_TIMERS interval timers behind an OPL index/data window.
// Ports: clk, rst_n, period_base, bus (slave) -> irq_n, ovf_pulse.
module opl_timer_bank
    import opl_timer_pkg::*;
#(
    parameter int         NUM_TIMERS = 2,
    parameter int         PERIOD_W   = 13,
    parameter int         UNIT_SHIFT = 2,
    parameter logic [8:0] IDX_PRESET = IDX_PRESET_D,
    parameter logic [8:0] IDX_CTRL   = IDX_CTRL_D,
    parameter logic [8:0] IDX_MASK   = IDX_MASK_D,
    parameter logic [8:0] IDX_MODE   = IDX_MODE_D,
    parameter logic [8:0] IDX_COUNT  = IDX_COUNT_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PERIOD_W-1:0]   period_base,
    opl_timer_bank_if.slave       bus,
    output logic                  irq_n,
    output logic [NUM_TIMERS-1:0] ovf_pulse
);

    localparam int NT    = NUM_TIMERS;
    localparam int SUB_W = sub_width(PERIOD_W, UNIT_SHIFT, NT);

    logic          we_d;
    logic [8:0]    index;
    logic [7:0]    preset [NT];
    logic [7:0]    cnt    [NT];
    logic [NT-1:0] start;
    logic [NT-1:0] start_nxt;
    logic [NT-1:0] mask;
    logic [NT-1:0] oneshot;
    logic [NT-1:0] flag;
    logic [NT-1:0] pulse;
    logic [NT-1:0] stop_req;
    logic          wr;
    logic          wr_idx;
    logic          wr_dat;
    logic          ctrl_hit;
    logic          ctrl_clr;
    logic          ctrl_set;
    logic [7:0]    stat;
    logic [7:0]    rdat;
    logic [7:0]    dout;

    assign wr       = bus.we & ~we_d;
    assign wr_idx   = wr & ~bus.addr[0];
    assign wr_dat   = wr & bus.addr[0];
    assign ctrl_hit = wr_dat & (index == IDX_CTRL);
    assign ctrl_clr = ctrl_hit & bus.din[7];
    assign ctrl_set = ctrl_hit & ~bus.din[7];

    // A one-shot stop overrides a simultaneous start write
    always_comb begin
        start_nxt = start;
        if (ctrl_set) start_nxt = bus.din[NT-1:0];
        start_nxt = start_nxt & ~stop_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_d    <= 1'b0;
            index   <= '0;
            start   <= '0;
            mask    <= '0;
            oneshot <= '0;
            flag    <= '0;
            irq_n   <= 1'b1;
            for (int i = 0; i < NT; i++) preset[i] <= 8'h00;
        end else begin
            we_d  <= bus.we;
            start <= start_nxt;
            if (wr_idx) index <= {bus.addr[1], bus.din};
            if (wr_dat && index == IDX_MASK) mask <= bus.din[NT-1:0];
            if (wr_dat && index == IDX_MODE) oneshot <= bus.din[NT-1:0];
            for (int i = 0; i < NT; i++) begin
                if (wr_dat && index != IDX_CTRL &&
                    index == 9'(IDX_PRESET + i))
                    preset[i] <= bus.din;
            end
            // Overflow set wins over a same-cycle flag reset
            flag <= (ctrl_clr ? '0 : flag) | pulse;
            if (|(pulse & ~mask)) irq_n <= 1'b0;
            else if (ctrl_clr)    irq_n <= 1'b1;
        end
    end

    always_comb begin
        stat           = 8'h00;
        stat[STAT_ANY] = |flag;
        for (int i = 0; i < NT; i++) stat[STAT_FLAG0-i] = flag[i];
        rdat = 8'h00;
        for (int i = 0; i < NT; i++) begin
            if (index == 9'(IDX_PRESET + i)) rdat = preset[i];
            if (index == 9'(IDX_COUNT + i))  rdat = cnt[i];
        end
        if (index == IDX_CTRL) rdat = 8'(start);
        if (index == IDX_MASK) rdat = 8'(mask);
        if (index == IDX_MODE) rdat = 8'(oneshot);
        case (bus.addr)
            2'd0:    dout = stat;
            2'd1:    dout = rdat;
            default: dout = 8'hFF;
        endcase
    end

    assign bus.dout  = dout;
    assign ovf_pulse = pulse;

    for (genvar g = 0; g < NT; g++) begin : g_tmr
        opl_timer_unit #(
            .PERIOD_W  (PERIOD_W),
            .UNIT_SHIFT(UNIT_SHIFT),
            .SUB_W     (SUB_W),
            .TIMER_IDX (g)
        ) u_tmr (
            .clk        (clk),
            .rst_n      (rst_n),
            .period_base(period_base),
            .start      (start[g]),
            .oneshot    (oneshot[g]),
            .preset     (preset[g]),
            .cnt        (cnt[g]),
            .pulse      (pulse[g]),
            .stop_req   (stop_req[g])
        );
    end

endmodule

// File: tb/tb_opl_timer_bank.sv
// tb_opl_timer_bank: self-checking bench for opl_timer_bank.
// Register vectors, latency sequences and randomized timer runs.
module tb_opl_timer_bank;

    localparam int NT = 2;
    localparam logic [8:0] I_PRE  = 9'h002;
    localparam logic [8:0] I_PRE1 = 9'h003;
    localparam logic [8:0] I_CTL  = 9'h004;
    localparam logic [8:0] I_MSK  = 9'h104;
    localparam logic [8:0] I_MOD  = 9'h105;
    localparam logic [8:0] I_CNT  = 9'h110;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [12:0]   period_base = '0;
    logic          irq_n;
    logic [NT-1:0] ovf;

    opl_timer_bank_if bus ();

    opl_timer_bank #(.NUM_TIMERS(NT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_base(period_base),
        .bus        (bus),
        .irq_n      (irq_n),
        .ovf_pulse  (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int wcyc = 0;

    typedef struct {
        logic [8:0] widx;
        logic [7:0] wdat;
        logic [8:0] ridx;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus write: strobe in the current cycle, then one idle cycle
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        wcyc     = cyc;
        @(negedge clk);
        bus.we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wreg(input logic [8:0] idx, input logic [7:0] d);
        wr({idx[8], 1'b0}, idx[7:0]);
        wr(2'b01, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        bus.addr = a;
        #1;
        v = bus.dout;
    endtask

    task automatic rreg(input logic [8:0] idx, output logic [7:0] v);
        wr({idx[8], 1'b0}, idx[7:0]);
        rd(2'b01, v);
    endtask

    task automatic wait_pulse(input int t, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            if (ovf[t]) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Live count of a running timer: preset plus whole units elapsed
    function automatic int exp_cnt(input int w, input int c,
                                   input int unit, input int pre);
        return (pre + (c - w - 2) / unit) & 255;
    endfunction

    function automatic logic [8:0] reg_idx(input int sel);
        case (sel)
            0:       return I_PRE;
            1:       return I_PRE1;
            2:       return I_MSK;
            default: return I_MOD;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int w, s, at, at2, np, frozen;
        int t, pb, pre, m, unit, n;
        logic [7:0] model [4];

        vt[0]  = '{9'h002, 8'h5A, 9'h002, 8'h5A};
        vt[1]  = '{9'h003, 8'hA5, 9'h003, 8'hA5};
        vt[2]  = '{9'h102, 8'h11, 9'h002, 8'h5A};
        vt[3]  = '{9'h104, 8'hFF, 9'h104, 8'h03};
        vt[4]  = '{9'h105, 8'h02, 9'h105, 8'h02};
        vt[5]  = '{9'h105, 8'h00, 9'h105, 8'h00};
        vt[6]  = '{9'h104, 8'h00, 9'h104, 8'h00};
        vt[7]  = '{9'h110, 8'h33, 9'h110, 8'h00};
        vt[8]  = '{9'h004, 8'h80, 9'h004, 8'h00};
        vt[9]  = '{9'h050, 8'h77, 9'h050, 8'h00};
        vt[10] = '{9'h003, 8'h00, 9'h002, 8'h5A};

        bus.addr = 2'b00;
        bus.din  = 8'h00;
        bus.we   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq", irq_n, 1);
        chk("rst_ovf", ovf, 0);
        rd(2'd0, v);
        chk("rst_status", v, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        rd(2'd2, v);
        chk("addr2_ff", v, 8'hFF);
        rd(2'd3, v);
        chk("addr3_ff", v, 8'hFF);
        rreg(I_CTL, v);
        chk("rst_ctrl", v, 8'h00);
        rreg(I_CNT, v);
        chk("rst_cnt0", v, 8'h00);

        for (int k = 0; k < 11; k++) begin
            wreg(vt[k].widx, vt[k].wdat);
            rreg(vt[k].ridx, v);
            chk($sformatf("vec%0d", k), v, vt[k].exp);
        end

        // Timer 0, preset FE, period_base 9: two units of 10 cycles
        period_base = 13'd9;
        wreg(I_PRE, 8'hFE);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        wait_pulse(0, 200, at);
        chk("t0_pulse_cycle", at, w + 22);
        rd(2'd0, v);
        chk("t0_status_early", v, 8'h00);
        @(negedge clk);
        chk("t0_pulse_width", ovf[0], 0);
        rd(2'd0, v);
        chk("t0_status", v, 8'hC0);
        chk("t0_irq", irq_n, 0);
        wreg(I_CTL, 8'h00);
        wreg(I_CTL, 8'h80);
        rd(2'd0, v);
        chk("t0_clear_status", v, 8'h00);
        chk("t0_clear_irq", irq_n, 1);

        // Timer 1: unit is 40 cycles
        wreg(I_PRE1, 8'hFF);
        wreg(I_CTL, 8'h02);
        w = wcyc;
        wait_pulse(1, 300, at);
        chk("t1_pulse_cycle", at, w + 42);
        @(negedge clk);
        rd(2'd0, v);
        chk("t1_status", v, 8'hA0);
        wait_pulse(1, 300, at2);
        chk("t1_repeat", at2 - at, 40);
        wreg(I_CTL, 8'h00);
        wreg(I_CTL, 8'h80);

        // Masked timer sets its flag but not the IRQ
        wreg(I_MSK, 8'h01);
        wreg(I_PRE, 8'hFF);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        wait_pulse(0, 200, at);
        chk("mask_pulse_cycle", at, w + 12);
        @(negedge clk);
        rd(2'd0, v);
        chk("mask_status", v, 8'hC0);
        chk("mask_irq", irq_n, 1);
        wreg(I_CTL, 8'h00);
        wreg(I_CTL, 8'h80);
        rd(2'd0, v);
        chk("mask_clear", v, 8'h00);
        wreg(I_MSK, 8'h00);

        // One-shot mode
        wreg(I_MOD, 8'h01);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        wait_pulse(0, 200, at);
        chk("os_pulse_cycle", at, w + 12);
        np = 0;
        repeat (60) begin
            @(negedge clk);
            if (ovf[0]) np++;
        end
        chk("os_extra_pulses", np, 0);
        rreg(I_CTL, v);
        chk("os_ctrl_readback", v, 8'h00);
        rreg(I_CNT, v);
        chk("os_cnt", v, 8'hFF);
        repeat (20) @(negedge clk);
        rd(2'd1, v);
        chk("os_cnt_hold", v, 8'hFF);
        wreg(I_CTL, 8'h80);
        wreg(I_MOD, 8'h00);
        chk("os_irq_clear", irq_n, 1);

        // Live count tracking, stop at F0, restart reloads preset
        period_base = 13'd3;
        wreg(I_PRE, 8'hE0);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        rreg(I_CNT, v);
        chk("cnt_first", v, exp_cnt(w, cyc, 4, 'hE0));
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rd(2'd1, v);
            chk("cnt_track", v, exp_cnt(w, cyc, 4, 'hE0));
            if (v == 8'hF0) break;
        end
        wreg(I_CTL, 8'h00);
        s = wcyc;
        frozen = exp_cnt(w, s + 1, 4, 'hE0);
        rreg(I_CNT, v);
        chk("cnt_stopped", v, frozen);
        repeat (20) @(negedge clk);
        rd(2'd1, v);
        chk("cnt_hold", v, frozen);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        rreg(I_CNT, v);
        chk("cnt_restart", v, 8'hE0);
        repeat (6) begin
            repeat (3) @(negedge clk);
            rd(2'd1, v);
            chk("cnt_retrack", v, exp_cnt(w, cyc, 4, 'hE0));
        end
        wreg(I_CTL, 8'h00);
        wreg(I_CTL, 8'h80);

        // Flag reset in the same cycle as the overflow pulse
        period_base = 13'd9;
        wreg(I_PRE, 8'hFE);
        wreg(I_CTL, 8'h01);
        w = wcyc;
        while (cyc < w + 22) @(negedge clk);
        chk("sc_pulse", ovf[0], 1);
        bus.addr = 2'b01;
        bus.din  = 8'h80;
        bus.we   = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        rd(2'd0, v);
        chk("sc_status", v, 8'hC0);
        chk("sc_irq", irq_n, 0);

        // Asynchronous reset mid-run
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_irq", irq_n, 1);
        rd(2'd0, v);
        chk("mr_status", v, 8'h00);
        chk("mr_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rreg(I_CNT, v);
        chk("mr_cnt", v, 8'h00);
        rreg(I_CTL, v);
        chk("mr_ctrl", v, 8'h00);

        // Randomized timer runs against the latency rule
        for (int it = 0; it < 8; it++) begin
            t   = $urandom_range(0, 1);
            pb  = $urandom_range(0, 3);
            pre = $urandom_range(250, 255);
            m   = $urandom_range(0, 1);
            unit = (pb + 1) << (2 * t);
            n    = 256 - pre;
            period_base = 13'(pb);
            wreg(I_MSK, 8'(m << t));
            wreg(9'(I_PRE + t), 8'(pre));
            wreg(I_CTL, 8'(1 << t));
            w = wcyc;
            wait_pulse(t, 500, at);
            chk($sformatf("rnd%0d_pulse", it), at, w + 2 + n * unit);
            @(negedge clk);
            rd(2'd0, v);
            chk($sformatf("rnd%0d_status", it), v, 8'('h80 | (1 << (6 - t))));
            chk($sformatf("rnd%0d_irq", it), irq_n, m);
            wait_pulse(t, 500, at2);
            chk($sformatf("rnd%0d_period", it), at2 - at, n * unit);
            wreg(I_CTL, 8'h00);
            wreg(I_CTL, 8'h80);
            chk($sformatf("rnd%0d_irq_clr", it), irq_n, 1);
        end

        // Randomized register writes against an array model
        for (int sel = 0; sel < 4; sel++) begin
            v = 8'($urandom);
            wreg(reg_idx(sel), v);
            model[sel] = (sel < 2) ? v : (v & 8'h03);
        end
        for (int it = 0; it < 12; it++) begin
            int ws, rs;
            ws = $urandom_range(0, 3);
            v  = 8'($urandom);
            wreg(reg_idx(ws), v);
            model[ws] = (ws < 2) ? v : (v & 8'h03);
            rs = $urandom_range(0, 3);
            rreg(reg_idx(rs), v);
            chk($sformatf("rreg%0d", it), v, model[rs]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
